tt_sel_seq: RTL
===============

Name: tt_sel_seq

Overview:
- On-chip sequencer that drives the design-select control lines: select-reset, select-increment and enable.
- Accepts a target user-module address over a valid/ready handshake.
- Emits the pulse train that makes the controller's address counter land on that address, then optionally raises the enable.
- Sits between the configuration/management logic and the controller's ctrl_sel_rst_n / ctrl_sel_inc / ctrl_ena inputs, in place of the host bit-banging those pads.

Parameters:
- ADDR_W, 10, width of the design address.
- MAX_ADDR, 1023, highest legal address; requests above it are rejected.
- PW_W, 8, width of the pulse-length configuration.

Ports:
- clk  input  1  block clock.
- rst_n  input  1  reset; synchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  block idle and able to accept.
- req_addr  input  ADDR_W  target address.
- req_ena  input  1  value to drive on ena after selection.
- cfg_pulse_len  input  PW_W  cycles per pulse phase; 0 is treated as 1.
- sel_rst_n  output  1  to controller ctrl_sel_rst_n.
- sel_inc  output  1  to controller ctrl_sel_inc.
- ena  output  1  to controller ctrl_ena.
- busy  output  1  sequence in progress.
- done  output  1  one-cycle pulse, sequence complete.
- err  output  1  one-cycle pulse, request rejected.
- cur_addr  output  ADDR_W  last successfully selected address.
- cur_valid  output  1  cur_addr meaningful.

Behaviour:
- Reset (rst_n low at a clk edge) puts the outputs at: sel_rst_n=1, sel_inc=0, ena=0, busy=0, done=0, err=0, cur_addr=0, cur_valid=0, state IDLE. Reset mid-sequence aborts immediately with these values.
- All outputs are registered. req_ready is combinational: (state==IDLE) && rst_n.
- Accept happens at edge T0 when req_valid && req_ready.
  - req_addr and req_ena are latched.
  - L = max(cfg_pulse_len,1) is latched; later cfg changes are ignored until the next accept.
- If req_addr > MAX_ADDR: err=1 for cycle T0+1, state stays IDLE, and all other outputs are unchanged (ena keeps its old value).
- States: IDLE -> RST -> GAP -> {INC_H -> INC_L}* -> FIN -> IDLE.
- RST: starts at T0+1. ena=0, sel_rst_n=0, busy=1, cur_valid=0. Lasts L cycles.
- GAP: sel_rst_n=1 for L cycles. The remaining-increment counter is loaded with the latched address.
  - If the counter is 0, go to FIN.
  - Else go to INC_H.
- INC_H: sel_inc=1 for L cycles.
- INC_L: sel_inc=0 for L cycles, then decrement the counter.
  - If the counter is now 0, go to FIN.
  - Else go to INC_H.
- FIN: a single cycle with these outputs:
  - done=1, busy=1;
  - ena=latched req_ena;
  - cur_addr=latched address, cur_valid=1.
  - Next state is IDLE with busy=0. ena holds its value in IDLE.
- Total busy duration for address A is 2L + 2L·A + 1 cycles. done asserts at cycle T0 + 2L + 2L·A + 1.
- sel_inc and sel_rst_n are never low/high respectively at the same time as the other is active.
- ena is 0 throughout RST..INC_L.
- The phase counter is PW_W bits wide. The increment counter is ADDR_W bits wide. L=2^PW_W−1 and A=MAX_ADDR must work without overflow.
- req_valid while busy: ignored, req_ready=0, no queuing.
- done and err are never both asserted.

Test Plan:
- Reset, then cfg_pulse_len=2, req addr=3, ena=1:
  - sel_rst_n low for cycles 1–2, high for 3–4;
  - sel_inc high at 5–6, 9–10, 13–14;
  - done at cycle 17 with ena=1, cur_addr=3, cur_valid=1;
  - req_ready low for cycles 1–17.
- Address 0, cfg_pulse_len=0 (treated as L=1): sel_rst_n low 1 cycle, gap 1 cycle, no sel_inc, done at cycle 3.
- req_addr=MAX_ADDR+1 with MAX_ADDR=5: err pulse next cycle, no sel_rst_n/sel_inc activity, prior ena and cur_addr retained.
- Second request and cfg_pulse_len change while busy: ignored; the first sequence completes with the original L, and the second request is accepted only after returning to IDLE.
- rst_n low during INC_H of addr=7: at the next edge sel_inc=0, sel_rst_n=1, ena=0, cur_valid=0, req_ready=1 after rst_n returns high.
- Back-to-back requests 4 (ena=0) then 2 (ena=1): ena stays 0 after the first; during the second it is 0 until FIN, then 1; cur_addr=2.

Source files
------------

// File: rtl/tt_sel_seq.sv
// Design-select sequencer: accepts a target address, then drives sel_rst_n / sel_inc
// so the controller's address counter lands on it, and finally applies the requested ena.
module tt_sel_seq #(
    parameter int ADDR_W   = 10,
    parameter int MAX_ADDR = 1023,
    parameter int PW_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_ena,
    input  logic [PW_W-1:0]   cfg_pulse_len,
    output logic              sel_rst_n,
    output logic              sel_inc,
    output logic              ena,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              cur_valid
);

    typedef enum logic [2:0] {
        IDLE,
        RST,
        GAP,
        INC_H,
        INC_L,
        FIN
    } state_t;

    // One extra bit so the range check stays meaningful when MAX_ADDR is all ones.
    localparam logic [ADDR_W:0] MAX_WIDE = (ADDR_W + 1)'(MAX_ADDR);

    state_t            state;
    logic [PW_W-1:0]   phase_cnt;
    logic [PW_W-1:0]   len_m1;
    logic [ADDR_W-1:0] inc_cnt;
    logic [ADDR_W-1:0] addr_lat;
    logic              ena_lat;

    logic              phase_end;
    logic              addr_bad;
    logic [PW_W-1:0]   start_len_m1;

    assign req_ready    = (state == IDLE) && rst_n;
    assign phase_end    = (phase_cnt == '0);
    assign addr_bad     = ({1'b0, req_addr} > MAX_WIDE);
    assign start_len_m1 = (cfg_pulse_len == '0) ? '0 : cfg_pulse_len - PW_W'(1);

    // Phase counter holds L-1 and counts down, so L = 2^PW_W-1 fits without overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel_rst_n <= 1'b1;
            sel_inc   <= 1'b0;
            ena       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            cur_addr  <= '0;
            cur_valid <= 1'b0;
            phase_cnt <= '0;
            len_m1    <= '0;
            inc_cnt   <= '0;
            addr_lat  <= '0;
            ena_lat   <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (addr_bad) begin
                            err <= 1'b1;
                        end else begin
                            addr_lat  <= req_addr;
                            ena_lat   <= req_ena;
                            len_m1    <= start_len_m1;
                            phase_cnt <= start_len_m1;
                            sel_rst_n <= 1'b0;
                            busy      <= 1'b1;
                            ena       <= 1'b0;
                            cur_valid <= 1'b0;
                            state     <= RST;
                        end
                    end
                end
                RST: begin
                    if (phase_end) begin
                        sel_rst_n <= 1'b1;
                        phase_cnt <= len_m1;
                        inc_cnt   <= addr_lat;
                        state     <= GAP;
                    end else begin
                        phase_cnt <= phase_cnt - PW_W'(1);
                    end
                end
                GAP: begin
                    if (phase_end) begin
                        if (inc_cnt == '0) begin
                            done      <= 1'b1;
                            ena       <= ena_lat;
                            cur_addr  <= addr_lat;
                            cur_valid <= 1'b1;
                            state     <= FIN;
                        end else begin
                            sel_inc   <= 1'b1;
                            phase_cnt <= len_m1;
                            state     <= INC_H;
                        end
                    end else begin
                        phase_cnt <= phase_cnt - PW_W'(1);
                    end
                end
                INC_H: begin
                    if (phase_end) begin
                        sel_inc   <= 1'b0;
                        phase_cnt <= len_m1;
                        state     <= INC_L;
                    end else begin
                        phase_cnt <= phase_cnt - PW_W'(1);
                    end
                end
                INC_L: begin
                    if (phase_end) begin
                        inc_cnt <= inc_cnt - ADDR_W'(1);
                        if (inc_cnt == ADDR_W'(1)) begin
                            done      <= 1'b1;
                            ena       <= ena_lat;
                            cur_addr  <= addr_lat;
                            cur_valid <= 1'b1;
                            state     <= FIN;
                        end else begin
                            sel_inc   <= 1'b1;
                            phase_cnt <= len_m1;
                            state     <= INC_H;
                        end
                    end else begin
                        phase_cnt <= phase_cnt - PW_W'(1);
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
